// File: rtl/fifo_pkg.sv
// Shared constants and parameter helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 32'sd0;
    localparam int FIFO_MODE_FWFT = 32'sd1;

    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    // True when DEPTH is a power of two >= 4 and both thresholds are legal.
    function automatic bit fifo_params_ok(input int depth, input int addr_bits,
                                          input int af_thresh, input int ae_thresh);
        return (depth >= 32'sd4)
            && ((depth & (depth - 32'sd1)) == 32'sd0)
            && (addr_bits + 32'sd1 == fifo_cnt_width(depth))
            && (af_thresh >= 32'sd1) && (af_thresh <= depth)
            && (ae_thresh >= 32'sd0) && (ae_thresh <= depth - 32'sd1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one write port, one read port that is either
// registered (standard mode) or asynchronous (first-word-fall-through).
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_BITS  = 4,
    parameter int REG_READ   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    if (REG_READ != 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] r_rd_data;

        // Read register loads only on an accepted read and holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data <= '0;
            end else if (rd_en) begin
                r_rd_data <= r_mem[rd_addr];
            end
        end

        assign rd_data = r_rd_data;
    end else begin : g_async_read
        assign rd_data = r_mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with standard/FWFT read mode, almost flags, sticky
// overflow/underflow flags and an occupancy high-water mark.
module sync_fifo_pro
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_BITS  = $clog2(DEPTH),
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  stat_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    count,
    output logic [ADDR_BITS:0]    max_count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ovf_sticky,
    output logic                  unf_sticky
);

    if (!fifo_params_ok(DEPTH, ADDR_BITS, AF_THRESH, AE_THRESH)) begin : g_param_check
        $error("sync_fifo_pro: DEPTH must be a power of two >= 4 with legal thresholds");
    end

    localparam int PW = ADDR_BITS + 1;
    localparam logic [PW-1:0] ONE_W   = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_count;
    logic [PW-1:0] r_max_count;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_ovf_sticky;
    logic          r_unf_sticky;
    logic          r_rd_valid;

    logic          w_rd_accept;
    logic          w_wr_accept;
    logic          w_ovf;
    logic          w_unf;
    logic [PW-1:0] w_cnt_next;
    logic [DATA_WIDTH-1:0] w_mem_rd_data;

    // A write into a full FIFO still succeeds when a read frees a slot in the same cycle.
    assign w_rd_accept = rd_en && !r_empty;
    assign w_wr_accept = wr_en && (!r_full || w_rd_accept);
    assign w_ovf       = wr_en && r_full && !w_rd_accept;
    assign w_unf       = rd_en && r_empty;

    // Occupancy after this edge.
    always_comb begin
        w_cnt_next = r_count;
        if (w_wr_accept && !w_rd_accept) begin
            w_cnt_next = r_count + ONE_W;
        end else if (w_rd_accept && !w_wr_accept) begin
            w_cnt_next = r_count - ONE_W;
        end else begin
            w_cnt_next = r_count;
        end
    end

    // Pointers, occupancy, flags, error pulses/stickies and the watermark.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_max_count    <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_ovf_sticky   <= 1'b0;
            r_unf_sticky   <= 1'b0;
            r_rd_valid     <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ONE_W;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + ONE_W;
            end
            r_count        <= w_cnt_next;
            r_full         <= (w_cnt_next == DEPTH_C);
            r_empty        <= (w_cnt_next == '0);
            r_almost_full  <= (w_cnt_next >= AF_C);
            r_almost_empty <= (w_cnt_next <= AE_C);
            r_overflow     <= w_ovf;
            r_underflow    <= w_unf;
            r_rd_valid     <= w_rd_accept;
            if (w_ovf) begin
                r_ovf_sticky <= 1'b1;
            end else if (stat_clr) begin
                r_ovf_sticky <= 1'b0;
            end
            if (w_unf) begin
                r_unf_sticky <= 1'b1;
            end else if (stat_clr) begin
                r_unf_sticky <= 1'b0;
            end
            if (stat_clr || (w_cnt_next > r_max_count)) begin
                r_max_count <= w_cnt_next;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_BITS  (ADDR_BITS),
        .REG_READ   ((FWFT == FIFO_MODE_STD) ? 32'sd1 : 32'sd0)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_accept && !rst),
        .wr_addr (r_wr_ptr[ADDR_BITS-1:0]),
        .wr_data (wr_data),
        .rd_en   (w_rd_accept),
        .rd_addr (r_rd_ptr[ADDR_BITS-1:0]),
        .rd_data (w_mem_rd_data)
    );

    assign rd_data      = w_mem_rd_data;
    assign rd_valid     = (FWFT == FIFO_MODE_FWFT) ? !r_empty : r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign max_count    = r_max_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign ovf_sticky   = r_ovf_sticky;
    assign unf_sticky   = r_unf_sticky;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Directed bench for sync_fifo_pro: a vector table for the standard-mode
// behaviour plus hand-written FWFT, wrap-around and mid-run reset sequences.
module tb_sync_fifo_pro;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       stat_clr = 1'b0;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid;
    logic       s_full, s_empty, s_af, s_ae, f_full, f_empty, f_af, f_ae;
    logic [4:0] s_count, s_max, f_count, f_max;
    logic       s_ovf, s_unf, s_ovfs, s_unfs, f_ovf, f_unf, f_ovfs, f_unfs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_fifo_pro #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .stat_clr(stat_clr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .max_count(s_max), .overflow(s_ovf), .underflow(s_unf),
        .ovf_sticky(s_ovfs), .unf_sticky(s_unfs)
    );

    sync_fifo_pro #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .stat_clr(stat_clr), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .max_count(f_max), .overflow(f_ovf), .underflow(f_unf),
        .ovf_sticky(f_ovfs), .unf_sticky(f_unfs)
    );

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       rdv;
        logic [7:0] rdd;
        logic       ovf;
        logic       unf;
        logic       ovfs;
        logic       unfs;
        int         mx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(logic wr, logic [7:0] wd, logic rd, logic clr, int cnt,
                                    logic rdv, logic [7:0] rdd, logic ovf, logic unf,
                                    logic ovfs, logic unfs, int mx);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr; v.cnt = cnt;
        v.rdv = rdv; v.rdd = rdd; v.ovf = ovf; v.unf = unf;
        v.ovfs = ovfs; v.unfs = unfs; v.mx = mx;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_std(input string tag, input vec_t v);
        chk({tag, " count"}, 32'(s_count), 32'(v.cnt));
        chk({tag, " full"}, 32'(s_full), 32'(v.cnt == 16));
        chk({tag, " empty"}, 32'(s_empty), 32'(v.cnt == 0));
        chk({tag, " almost_full"}, 32'(s_af), 32'(v.cnt >= 14));
        chk({tag, " almost_empty"}, 32'(s_ae), 32'(v.cnt <= 2));
        chk({tag, " rd_valid"}, 32'(s_rd_valid), 32'(v.rdv));
        chk({tag, " rd_data"}, 32'(s_rd_data), 32'(v.rdd));
        chk({tag, " overflow"}, 32'(s_ovf), 32'(v.ovf));
        chk({tag, " underflow"}, 32'(s_unf), 32'(v.unf));
        chk({tag, " ovf_sticky"}, 32'(s_ovfs), 32'(v.ovfs));
        chk({tag, " unf_sticky"}, 32'(s_unfs), 32'(v.unfs));
        chk({tag, " max_count"}, 32'(s_max), 32'(v.mx));
    endtask

    task automatic check_reset(input string tag);
        vec_t v;
        v.wr = 1'b0; v.wd = 8'h00; v.rd = 1'b0; v.clr = 1'b0; v.cnt = 0;
        v.rdv = 1'b0; v.rdd = 8'h00; v.ovf = 1'b0; v.unf = 1'b0;
        v.ovfs = 1'b0; v.unfs = 1'b0; v.mx = 0;
        check_std(tag, v);
        chk({tag, " fwft count"}, 32'(f_count), 32'd0);
        chk({tag, " fwft rd_valid"}, 32'(f_rd_valid), 32'd0);
        chk({tag, " fwft empty"}, 32'(f_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;

        // Fill, overflow, drain, underflow, clear, full/empty simultaneous access.
        for (int i = 0; i < 16; i++) add_vec(1'b1, 8'(i), 1'b0, 1'b0, i + 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, i + 1);
        add_vec(1'b1, 8'hAA, 1'b0, 1'b0, 16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16);
        for (int j = 0; j < 16; j++) add_vec(1'b0, 8'h00, 1'b1, 1'b0, 15 - j, 1'b1, 8'(j), 1'b0, 1'b0, 1'b1, 1'b0, 16);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 16);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b1, 16);
        add_vec(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 16; i++) add_vec(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, i + 1, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, i + 1);
        add_vec(1'b1, 8'h30, 1'b1, 1'b0, 16, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        for (int j = 0; j < 16; j++) add_vec(1'b0, 8'h00, 1'b1, 1'b0, 15 - j, 1'b1, (j < 15) ? 8'(8'h21 + j) : 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 16);
        add_vec(1'b1, 8'h40, 1'b1, 1'b0, 1, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 1'b1, 16);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 16);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("reset");

        for (int k = 0; k < vecs.size(); k++) begin
            wr_en = vecs[k].wr; wr_data = vecs[k].wd; rd_en = vecs[k].rd; stat_clr = vecs[k].clr;
            step();
            check_std($sformatf("v%0d", k), vecs[k]);
        end
        wr_en = 1'b0; rd_en = 1'b0; stat_clr = 1'b0;

        // FWFT: head word visible without rd_en, next word after the popping edge.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_en = 1'b1; wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        chk("fwft first rd_valid", 32'(f_rd_valid), 32'd1);
        chk("fwft first rd_data", 32'(f_rd_data), 32'h55);
        chk("fwft first count", 32'(f_count), 32'd1);
        step();
        chk("fwft hold rd_data", 32'(f_rd_data), 32'h55);
        chk("fwft std no rd_valid", 32'(s_rd_valid), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("fwft pop empty", 32'(f_empty), 32'd1);
        chk("fwft pop rd_valid", 32'(f_rd_valid), 32'd0);
        wr_en = 1'b1; wr_data = 8'h66;
        step();
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        chk("fwft head 66", 32'(f_rd_data), 32'h66);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("fwft head 77", 32'(f_rd_data), 32'h77);
        chk("fwft head 77 valid", 32'(f_rd_valid), 32'd1);

        // Wrap-around with a running scoreboard, then reset while count is 5.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("wrap pre underflow", 32'(s_unf), 32'd1);
        chk("wrap pre unf_sticky", 32'(s_unfs), 32'd1);
        for (int k = 0; k < 40; k++) begin
            wr_en = 1'b1; wr_data = 8'(k); rd_en = (k >= 5);
            q.push_back(8'(k));
            exp_d = 8'h00;
            if (k >= 5) exp_d = q.pop_front();
            step();
            chk($sformatf("wrap%0d count", k), 32'(s_count), 32'((k < 5) ? k + 1 : 5));
            chk($sformatf("wrap%0d rd_valid", k), 32'(s_rd_valid), 32'(k >= 5));
            if (k >= 5) chk($sformatf("wrap%0d rd_data", k), 32'(s_rd_data), 32'(exp_d));
        end
        chk("wrap max_count", 32'(s_max), 32'd5);
        chk("wrap unf_sticky kept", 32'(s_unfs), 32'd1);
        wr_data = 8'hEE;
        rst = 1'b1;
        step();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_reset("midrun reset");
        step();
        chk("post reset count", 32'(s_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
